fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_addr  output  32  word-aligned read address, equal to pc.
REQ-006 SHALL have port imem_ack  input  1  memory has imem_rdata valid this cycle.
REQ-007 SHALL have port imem_rdata  input  32  instruction word from memory.
REQ-008 SHALL have port instruction  output  32  registered instruction presented to the decoder.
REQ-009 SHALL have port instr_valid  output  1  instruction holds a fetched, unconsumed word.
REQ-010 SHALL have port instr_taken  input  1  the downstream stage consumes instruction at this edge.
REQ-011 SHALL have port is_jump  input  1  decoded instruction is an absolute jump.
REQ-012 SHALL have port is_branch  input  1  decoded instruction is a conditional branch.
REQ-013 SHALL have port branch_taken  input  1  branch condition evaluated true.
REQ-014 SHALL have port imm16  input  16  branch offset in words.
REQ-015 SHALL have port addr26  input  26  jump target field.
REQ-016 SHALL have port pc  output  32  address of the current instruction.
REQ-017 SHALL have port pc_plus4  output  32  pc + 4 (modulo 2^32), for link writes.

Function
REQ-018 SHALL implement states IDLE, FETCH, HOLD.
REQ-019 SHALL go IDLE -> FETCH on the first clock edge after reset deasserts.
REQ-020 SHALL in FETCH drive imem_req=1 and imem_addr=pc; in IDLE and HOLD drive imem_req=0.
REQ-021 SHALL in FETCH, on an edge with imem_ack=1, latch imem_rdata into instruction, set instr_valid=1, go HOLD (instr_valid rises one cycle after the ack cycle).
REQ-022 SHALL ignore imem_ack and imem_rdata in IDLE and HOLD.
REQ-023 SHALL in HOLD keep instruction and pc stable until an edge with instr_taken=1; at that edge pc <= next_pc, instr_valid <= 0, state <= FETCH.
REQ-024 SHALL ignore instr_taken when instr_valid=0.
REQ-025 SHALL compute next_pc with priority: is_jump -> {pc_plus4[31:28], addr26, 2'b00}; else is_branch & branch_taken -> pc_plus4 + (sign-extended imm16 << 2); else pc_plus4.
REQ-026 SHALL perform all pc arithmetic in 32 bits, discarding carry (0xFFFF_FFFC + 4 = 0x0000_0000).
REQ-027 SHALL keep pc[1:0] = 2'b00 at all times, forcing the low two bits of any computed target to zero.
REQ-028 SHALL sustain one instruction per two cycles when imem_ack and instr_taken are held at 1.
REQ-029 SHALL hold FETCH with imem_req=1 and unchanged imem_addr for any number of cycles while imem_ack=0.

Reset
REQ-030 SHALL, while reset=1 and independent of clk, force state=IDLE, pc=RESET_PC, instruction=32'h0, instr_valid=0, imem_req=0.
REQ-031 SHALL on reset mid-FETCH drop imem_req immediately and discard any ack arriving in the same cycle.
REQ-032 SHALL on reset mid-HOLD discard the held instruction; the fetch restarts at RESET_PC.

Verification
REQ-033 Reset release, ack on 1st FETCH cycle, imem_rdata=32'h2010FEFE -> imem_addr=0, instruction=32'h2010FEFE and instr_valid=1 the next cycle, pc=0.
REQ-034 Sequential: take with is_jump=0, is_branch=0 at pc=0x40 -> imem_addr=0x44; instr_valid=0 until the next ack.
REQ-035 Branch: pc=0x100, is_branch=1, branch_taken=1, imm16=16'hFFFD -> pc=0xF8; with branch_taken=0 -> pc=0x104.
REQ-036 Jump: pc=0x9000_0010, is_jump=1, is_branch=1, addr26=26'h0000400 -> pc=0x9000_1000.
REQ-037 Stalls: imem_ack low 5 cycles -> imem_req held 1 and imem_addr constant; instr_taken low 3 cycles in HOLD -> instruction and pc unchanged.
REQ-038 Reset asserted between clock edges during FETCH with imem_ack=1 -> imem_req=0 and instr_valid=0 immediately; after release the first request is to RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. It issues one read request at a time to the
// instruction memory and waits for the acknowledge. It then holds the
// returned word for the decoder until the word is consumed. When the word is
// consumed, the unit steps the program counter to the sequential, branch or
// jump target.
//
// Parameters
//   RESET_PC      address of the first instruction fetched after reset
//
// Ports
//   clk           clock, all state changes on its rising edge
//   reset         asynchronous, active-high reset
//   imem_req      instruction-memory read request (high in FETCH)
//   imem_addr     word-aligned read address, always equal to pc
//   imem_ack      memory has imem_rdata valid this cycle
//   imem_rdata    instruction word from memory
//   instruction   registered instruction presented to the decoder
//   instr_valid   instruction holds a fetched, unconsumed word
//   instr_taken   downstream stage consumes instruction at this edge
//   is_jump       decoded instruction is an absolute jump
//   is_branch     decoded instruction is a conditional branch
//   branch_taken  branch condition evaluated true
//   imm16         branch offset in words
//   addr26        jump target field
//   pc            address of the current instruction
//   pc_plus4      pc + 4 (wraps modulo 2^32), used for link writes
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_taken,
  input  logic        is_jump,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] addr26,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t      state;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc;

  // All pc arithmetic is plain 32-bit, so a carry out of bit 31 is simply lost.
  assign pc_plus4      = pc + 32'd4;
  assign branch_offset = {{14{imm16[15]}}, imm16, 2'b00};
  assign branch_target = pc_plus4 + branch_offset;
  assign jump_target   = {pc_plus4[31:28], addr26, 2'b00};
  assign imem_addr     = pc;

  // A jump wins over a branch when the decoder flags both.
  always_comb begin
    next_pc = pc_plus4;
    if (is_jump) begin
      next_pc = jump_target;
    end else if (is_branch && branch_taken) begin
      next_pc = branch_target;
    end
  end

  // Fetch FSM. imem_req is registered and tracks entry into FETCH, so the
  // async reset drops it immediately. An ack that arrives while reset is
  // high is therefore lost. pc is masked on every update so that it always
  // stays word aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC & 32'hFFFF_FFFC;
      instruction <= 32'h0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instruction <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_taken && instr_valid) begin
            pc          <= next_pc & 32'hFFFF_FFFC;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
          imem_req    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. It uses three instances that share the
// same inputs:
//   dut      RESET_PC = 0            main sequence
//   dut_hi   RESET_PC = 0x9000_0010  jump keeps the upper pc nibble
//   dut_wrap RESET_PC = 0xFFFF_FFFC  pc_plus4 wraps to zero
// Inputs change 1 time unit after a rising edge. Outputs are sampled at
// the same point.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_taken;
  logic        is_jump;
  logic        is_branch;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [25:0] addr26;

  logic        imem_req,    hi_imem_req,    wr_imem_req;
  logic [31:0] imem_addr,   hi_imem_addr,   wr_imem_addr;
  logic [31:0] instruction, hi_instruction, wr_instruction;
  logic        instr_valid, hi_instr_valid, wr_instr_valid;
  logic [31:0] pc,          hi_pc,          wr_pc;
  logic [31:0] pc_plus4,    hi_pc_plus4,    wr_pc_plus4;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid),
    .instr_taken(instr_taken), .is_jump(is_jump), .is_branch(is_branch),
    .branch_taken(branch_taken), .imm16(imm16), .addr26(addr26),
    .pc(pc), .pc_plus4(pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'h9000_0010)) dut_hi (
    .clk(clk), .reset(reset),
    .imem_req(hi_imem_req), .imem_addr(hi_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(hi_instruction), .instr_valid(hi_instr_valid),
    .instr_taken(instr_taken), .is_jump(is_jump), .is_branch(is_branch),
    .branch_taken(branch_taken), .imm16(imm16), .addr26(addr26),
    .pc(hi_pc), .pc_plus4(hi_pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(wr_imem_req), .imem_addr(wr_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(wr_instruction), .instr_valid(wr_instr_valid),
    .instr_taken(instr_taken), .is_jump(is_jump), .is_branch(is_branch),
    .branch_taken(branch_taken), .imm16(imm16), .addr26(addr26),
    .pc(wr_pc), .pc_plus4(wr_pc_plus4)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drives every input except reset in one call.
  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic taken, input logic jmp,
                               input logic br, input logic btaken,
                               input logic [15:0] imm,
                               input logic [25:0] addr);
    imem_ack     = ack;
    imem_rdata   = rdata;
    instr_taken  = taken;
    is_jump      = jmp;
    is_branch    = br;
    branch_taken = btaken;
    imm16        = imm;
    addr26       = addr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in FETCH. Acknowledges immediately and checks the HOLD result.
  task automatic fetchWord(input logic [31:0] word);
    applyStimulus(1'b1, word, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    tick();
    checkOutput("fetch_instr", instruction, word);
    checkOutput("fetch_valid", {31'b0, instr_valid}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
  endtask

  // Called in HOLD. Consumes the word with the given decode and checks the new pc.
  task automatic takeWord(input string tag, input logic jmp, input logic br,
                          input logic btaken, input logic [15:0] imm,
                          input logic [25:0] addr,
                          input logic [31:0] exp_pc);
    applyStimulus(1'b0, 32'h0, 1'b1, jmp, br, btaken, imm, addr);
    tick();
    checkOutput(tag, pc, exp_pc);
    checkOutput({tag, "_addr"}, imem_addr, exp_pc);
    checkOutput({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    checkOutput({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    #2;
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_instr", instruction, 32'h0);
    checkOutput("rst_hi_pc", hi_pc, 32'h9000_0010);
    checkOutput("wrap_pc_plus4", wr_pc_plus4, 32'h0000_0000);

    tick();
    reset = 1'b0;
    tick();
    checkOutput("first_req", {31'b0, imem_req}, 32'd1);
    checkOutput("first_addr", imem_addr, 32'h0);

    // The ack comes on the first FETCH cycle.
    fetchWord(32'h2010_FEFE);
    checkOutput("first_pc", pc, 32'h0);

    // Hold for 3 cycles. A stray ack with new data must be ignored.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
      tick();
      checkOutput("hold_instr", instruction, 32'h2010_FEFE);
      checkOutput("hold_pc", pc, 32'h0);
      checkOutput("hold_valid", {31'b0, instr_valid}, 32'd1);
      checkOutput("hold_req", {31'b0, imem_req}, 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);

    // Jump wins over branch. It keeps the top nibble of pc+4.
    takeWord("jump_low", 1'b1, 1'b1, 1'b1, 16'hFFFD, 26'h000_0400, 32'h0000_1000);
    checkOutput("jump_hi", hi_pc, 32'h9000_1000);

    // Memory stalls for 5 cycles. instr_taken is high but must be ignored.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
      tick();
      checkOutput("stall_req", {31'b0, imem_req}, 32'd1);
      checkOutput("stall_addr", imem_addr, 32'h0000_1000);
      checkOutput("stall_valid", {31'b0, instr_valid}, 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);

    fetchWord(32'h1111_1111);
    takeWord("jump_40", 1'b1, 1'b0, 1'b0, 16'h0, 26'h000_0010, 32'h0000_0040);
    fetchWord(32'h2222_2222);
    takeWord("seq_44", 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_0044);
    tick();
    checkOutput("seq_no_ack_valid", {31'b0, instr_valid}, 32'd0);

    fetchWord(32'h3333_3333);
    takeWord("jump_100", 1'b1, 1'b0, 1'b0, 16'h0, 26'h000_0040, 32'h0000_0100);
    fetchWord(32'h4444_4444);
    takeWord("branch_back", 1'b0, 1'b1, 1'b1, 16'hFFFD, 26'h0, 32'h0000_00F8);
    fetchWord(32'h5555_5555);
    takeWord("jump_100b", 1'b1, 1'b0, 1'b0, 16'h0, 26'h000_0040, 32'h0000_0100);
    fetchWord(32'h6666_6666);
    takeWord("branch_not", 1'b0, 1'b1, 1'b0, 16'hFFFD, 26'h0, 32'h0000_0104);
    fetchWord(32'h7777_7777);
    takeWord("branch_fwd", 1'b0, 1'b1, 1'b1, 16'h0010, 26'h0, 32'h0000_0148);

    // With ack and taken both held high, one word completes every two cycles.
    applyStimulus(1'b1, 32'hABCD_0001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    tick();
    checkOutput("tp1_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("tp1_pc", pc, 32'h0000_0148);
    tick();
    checkOutput("tp2_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("tp2_pc", pc, 32'h0000_014C);
    tick();
    checkOutput("tp3_valid", {31'b0, instr_valid}, 32'd1);
    tick();
    checkOutput("tp4_pc", pc, 32'h0000_0150);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);

    // Reset arrives between edges in FETCH while ack is high.
    applyStimulus(1'b1, 32'hCAFE_BABE, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rstf_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rstf_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rstf_pc", pc, 32'h0);
    tick();
    checkOutput("rstf_instr", instruction, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    reset = 1'b0;
    tick();
    checkOutput("rstf_after_req", {31'b0, imem_req}, 32'd1);
    checkOutput("rstf_after_addr", imem_addr, 32'h0);

    // Reset arrives in HOLD. The held word is dropped.
    fetchWord(32'h55AA_55AA);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rsth_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rsth_instr", instruction, 32'h0);
    checkOutput("rsth_pc", pc, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("rsth_after_req", {31'b0, imem_req}, 32'd1);
    checkOutput("rsth_after_addr", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
